// File: rtl/div_seq_ctrl.sv
// Multi-cycle non-restoring divider sequencer: one iteration per clock, sign fix-up, done pulse.
// Optional macro DIV_SHORTCUT_EN: skip iterations when |dividend| < |divisor|.
module div_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] q_reg, d_reg;
    logic [WIDTH:0]   r_reg;
    logic [CNT_W-1:0] cnt;
    logic             q_sign, r_sign;

    logic             a_neg, b_neg, b_zero, short_cut, accept, last;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   d_ext, r_shift, r_new, r_fix;

    assign a_neg  = signed_op & dividend[WIDTH-1];
    assign b_neg  = signed_op & divisor[WIDTH-1];
    assign a_mag  = a_neg ? -dividend : dividend;
    assign b_mag  = b_neg ? -divisor : divisor;
    assign b_zero = (divisor == '0);
    assign last   = (cnt == CNT_W'(WIDTH - 1));

`ifdef DIV_SHORTCUT_EN
    assign short_cut = (a_mag < b_mag);
`else
    assign short_cut = 1'b0;
`endif

    // R is kept modulo 2^(WIDTH+1); the true value always lies in [-D, D) so the wrap is harmless.
    assign d_ext   = {1'b0, d_reg};
    assign r_shift = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};
    assign r_new   = r_reg[WIDTH] ? (r_shift + d_ext) : (r_shift - d_ext);
    assign r_fix   = r_reg[WIDTH] ? (r_reg + d_ext) : r_reg;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        accept   = 1'b0;
        case (state)
            IDLE, DONE: begin
                done   = (state == DONE);
                accept = start;
                if (start) state_nx = (b_zero || short_cut) ? DONE : ITER;
                else       state_nx = IDLE;
            end
            ITER: begin
                busy = 1'b1;
                if (last) state_nx = FIX;
            end
            FIX: begin
                busy     = 1'b1;
                state_nx = DONE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            q_reg       <= '0;
            d_reg       <= '0;
            r_reg       <= '0;
            cnt         <= '0;
            q_sign      <= 1'b0;
            r_sign      <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            q_reg       <= a_mag;
            d_reg       <= b_mag;
            r_reg       <= '0;
            cnt         <= '0;
            q_sign      <= a_neg ^ b_neg;
            r_sign      <= a_neg;
            div_by_zero <= b_zero;
            if (b_zero) begin
                quotient  <= '1;
                remainder <= dividend;
            end else if (short_cut) begin
                quotient  <= '0;
                remainder <= dividend;
            end
        end else if (state == ITER) begin
            r_reg <= r_new;
            q_reg <= {q_reg[WIDTH-2:0], ~r_new[WIDTH]};
            cnt   <= cnt + CNT_W'(1);
        end else if (state == FIX) begin
            quotient  <= q_sign ? -q_reg : q_reg;
            remainder <= r_sign ? -r_fix[WIDTH-1:0] : r_fix[WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: arithmetic reference model checked every cycle plus directed literals.
module tb_div_seq_ctrl;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         clear = 1'b1;
    logic         start = 1'b0;
    logic         signed_op = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    int n_cmp = 0;
    int n_fail = 0;

    div_seq_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
        .clock(clock), .clear(clear), .start(start), .signed_op(signed_op),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference arithmetic straight from the architectural rules.
    task automatic ref_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] q, output logic [W-1:0] r,
                           output logic dz, output logic fast);
        logic [W-1:0] ma, mb;
        ma = (sgn && a[W-1]) ? -a : a;
        mb = (sgn && b[W-1]) ? -b : b;
        dz = (b == 0);
        fast = dz;
`ifdef DIV_SHORTCUT_EN
        if (!dz && ma < mb) fast = 1'b1;
`endif
        if (dz) begin
            q = '1; r = a;
        end else if (ma < mb) begin
            q = '0; r = a;
        end else if (!sgn) begin
            q = a / b; r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = '0;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
    endtask

    logic         m_busy = 0, m_done = 0, m_dz = 0;
    int           m_left = 0;
    logic [W-1:0] m_q = '0, m_r = '0, p_q, p_r;

    always @(posedge clock or negedge clear) begin
        logic dz, fast;
        if (!clear) begin
            m_busy = 0; m_done = 0; m_dz = 0; m_left = 0; m_q = '0; m_r = '0;
        end else begin
            m_done = 0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 0; m_done = 1; m_q = p_q; m_r = p_r;
                end
            end else if (start) begin
                ref_div(signed_op, dividend, divisor, p_q, p_r, dz, fast);
                m_dz = dz;
                if (fast) begin
                    m_done = 1; m_q = p_q; m_r = p_r;
                end else begin
                    m_busy = 1; m_left = W + 1;
                end
            end
        end
    end

    always @(negedge clock) begin
        n_cmp++;
        if (busy !== m_busy || done !== m_done || div_by_zero !== m_dz ||
            quotient !== m_q || remainder !== m_r) begin
            n_fail++;
            $display("FAIL model t=%0t: got busy=%b done=%b dz=%b q=%h r=%h expected busy=%b done=%b dz=%b q=%h r=%h",
                     $time, busy, done, div_by_zero, quotient, remainder,
                     m_busy, m_done, m_dz, m_q, m_r);
        end
    end

    // Called #1 after a posedge; leaves start low #1 after the sampling edge.
    task automatic start_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1; signed_op = sgn; dividend = a; divisor = b;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int n0, input int exp_edges,
                             input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
        int n = n0;
        while (!done && n < 120) begin
            @(posedge clock); #1;
            n++;
        end
        chk({name, " edges"}, W'(n), W'(exp_edges));
        chk({name, " q"}, quotient, eq);
        chk({name, " r"}, remainder, er);
        chk({name, " dz"}, W'(div_by_zero), W'(edz));
        chk({name, " busy"}, W'(busy), 0);
    endtask

    initial begin
        int dones;
        #1 clear = 1'b0;
        #2;
        chk("reset q", quotient, 0);
        chk("reset r", remainder, 0);
        chk("reset flags", W'({busy, done, div_by_zero}), 0);
        @(posedge clock); #1 clear = 1'b1;
        @(posedge clock); #1;

        start_op(0, 100, 5);
        wait_done("u100/5", 1, 34, 20, 0, 0);
        @(posedge clock); #1;

        start_op(0, 32'h7FFF_FFFF, 32'h0000_FFFF);
        wait_done("u7fffffff/ffff", 1, 34, 32'h0000_8000, 32'h0000_7FFF, 0);
        start_op(0, 200, 7);
        wait_done("b2b 200/7", 1, 34, 28, 4, 0);
        @(posedge clock); #1;

        start_op(1, 32'hFFFF_FFDB, 6);
        wait_done("s-37/6", 1, 34, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 0);
        start_op(1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("s overflow", 1, 34, 32'h8000_0000, 0, 0);
        @(posedge clock); #1;

        start_op(0, 50, 0);
        wait_done("div0", 1, 1, 32'hFFFF_FFFF, 50, 1);
        @(posedge clock); #1;
        chk("div0 held", W'(div_by_zero), 1);
        start_op(0, 1, 1);
        chk("dz clr on start", W'(div_by_zero), 0);
        chk("q held on start", quotient, 32'hFFFF_FFFF);
        wait_done("1/1", 1, 34, 1, 0, 0);
        @(posedge clock); #1;

        start_op(0, 255, 15);
        repeat (10) begin @(posedge clock); #1; end
        start = 1'b1; dividend = 1; divisor = 1;
        @(posedge clock); #1;
        start = 1'b0;
        wait_done("ignored start", 12, 34, 17, 0, 0);
        @(posedge clock); #1;

        start_op(0, 1024, 32);
        repeat (20) begin @(posedge clock); #1; end
        clear = 1'b0;
        #1;
        chk("abort q", quotient, 0);
        chk("abort r", remainder, 0);
        chk("abort flags", W'({busy, done, div_by_zero}), 0);
        @(posedge clock); #1 clear = 1'b1;
        dones = 0;
        repeat (40) begin @(posedge clock); #1; if (done) dones++; end
        chk("no done after abort", W'(dones), 0);
        start_op(0, 1024, 32);
        wait_done("1024/32", 1, 34, 32, 0, 0);
        @(posedge clock); #1;

        start_op(0, 3, 7);
`ifdef DIV_SHORTCUT_EN
        wait_done("3/7", 1, 1, 0, 3, 0);
`else
        wait_done("3/7", 1, 34, 0, 3, 0);
`endif
        repeat (3) @(posedge clock);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
